// File: rtl/eig_core_mc.sv
// Multi-channel eigen-regime core: regime, sigma, kappa and 1/kappa of x''+a1*x'+a0*x=0.
// Optional EIG_CORE_MC_REGIME_CNT_EN adds saturating per-regime result counters.
module eig_core_mc #(
    parameter int W   = 32,
    parameter int F   = 16,
    parameter int NCH = 4,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   a1,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output logic [2:0]     regime,
    output logic           regime_chg,
    output logic [W-1:0]   sigma,
    output logic [W-1:0]   kappa,
    output logic [W-1:0]   inv_kappa,
    output logic           inv_invalid,
`ifdef EIG_CORE_MC_REGIME_CNT_EN
    input  logic           cnt_clr,
    output logic [15:0]    cnt_over,
    output logic [15:0]    cnt_crit,
    output logic [15:0]    cnt_under,
`endif
    output logic           core_busy
);

    typedef enum logic [2:0] {S_IDLE, S_DISC, S_SQRT, S_DIV, S_OUT} state_t;

    localparam int QW   = 2 * F + 1;
    localparam int RW   = W + 4;
    localparam int XW   = QW + W;
    localparam int CNTW = $clog2(W + 2 * F + 2);
    localparam logic [W-1:0] MAXPOS = {1'b0, {(W-1){1'b1}}};

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              core_busy_q, core_busy_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic [W-1:0]      a0_q, a0_d, a1_q, a1_d;
    logic [2:0]        regime_q, regime_d;
    logic              regime_chg_q, regime_chg_d;
    logic [W-1:0]      sigma_q, sigma_d;
    logic [W-1:0]      kappa_q, kappa_d;
    logic [W-1:0]      inv_kappa_q, inv_kappa_d;
    logic              inv_invalid_q, inv_invalid_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]    rad_q, rad_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [W-1:0]      root_q, root_d;
    logic [QW-1:0]     dvd_q, dvd_d;
    logic [W-1:0]      drem_q, drem_d;
    logic [QW-1:0]     quo_q, quo_d;
    logic [2:0]        mem_q [NCH];
    logic [2:0]        mem_d [NCH];

    logic signed [2*W+1:0] a1_ext, a0_ext, disc;
    logic [2*W+1:0]        disc_abs;
    logic [W:0]            neg_a1;
    logic [RW-1:0]         rem_sh, rem_n;
    logic [W:0]            drem_sh;
    logic                  div_ge;
    logic [QW-1:0]         quo_n;
    logic                  ch_ok, chg_next, div_sat;
    logic                  unused_bits;

    // Exact discriminant in Q(2F): a1^2 - 4*a0, widened so nothing can overflow.
    assign a1_ext   = signed'({{(W+2){a1_q[W-1]}}, a1_q});
    assign a0_ext   = signed'({{(W+2){a0_q[W-1]}}, a0_q});
    assign disc     = a1_ext * a1_ext - (a0_ext <<< (F + 2));
    assign disc_abs = disc[2*W+1] ? -disc : disc;
    assign neg_a1   = -{a1_q[W-1], a1_q};

    // Non-restoring root step: remainder sign selects add or subtract of the trial term.
    assign rem_sh = {rem_q[RW-3:0], rad_q[2*W-1 -: 2]};
    assign rem_n  = rem_q[RW-1] ? rem_sh + {2'b00, root_q, 2'b11}
                                : rem_sh - {2'b00, root_q, 2'b01};

    assign drem_sh = {drem_q, dvd_q[QW-1]};
    assign div_ge  = drem_sh >= {1'b0, kappa_q};
    assign quo_n   = {quo_q[QW-2:0], div_ge};
    assign div_sat = XW'(quo_n) > XW'(MAXPOS);

    assign ch_ok    = int'(ch_q) < NCH;
    assign chg_next = ch_ok ? (mem_q[ch_q] != regime_q) : 1'b1;

    assign unused_bits = ^{disc_abs[2*W+1:2*W], neg_a1[0], rem_q[RW-2], quo_q[QW-1]};

`ifdef EIG_CORE_MC_REGIME_CNT_EN
    logic [15:0] cnt_over_q, cnt_over_d, cnt_crit_q, cnt_crit_d, cnt_under_q, cnt_under_d;
    logic        out_hs;

    assign out_hs = (state_q == S_OUT) && out_ready;

    always_comb begin
        cnt_over_d  = cnt_over_q;
        cnt_crit_d  = cnt_crit_q;
        cnt_under_d = cnt_under_q;
        if (cnt_clr) begin
            cnt_over_d  = '0;
            cnt_crit_d  = '0;
            cnt_under_d = '0;
        end else if (out_hs) begin
            if (regime_q == 3'b100 && cnt_over_q != 16'hFFFF)  cnt_over_d  = cnt_over_q + 16'd1;
            if (regime_q == 3'b010 && cnt_crit_q != 16'hFFFF)  cnt_crit_d  = cnt_crit_q + 16'd1;
            if (regime_q == 3'b001 && cnt_under_q != 16'hFFFF) cnt_under_d = cnt_under_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_over_q  <= '0;
            cnt_crit_q  <= '0;
            cnt_under_q <= '0;
        end else begin
            cnt_over_q  <= cnt_over_d;
            cnt_crit_q  <= cnt_crit_d;
            cnt_under_q <= cnt_under_d;
        end
    end

    assign cnt_over  = cnt_over_q;
    assign cnt_crit  = cnt_crit_q;
    assign cnt_under = cnt_under_q;
`endif

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        a0_d          = a0_q;
        a1_d          = a1_q;
        regime_d      = regime_q;
        regime_chg_d  = regime_chg_q;
        sigma_d       = sigma_q;
        kappa_d       = kappa_q;
        inv_kappa_d   = inv_kappa_q;
        inv_invalid_d = inv_invalid_q;
        cnt_d         = cnt_q;
        rad_d         = rad_q;
        rem_d         = rem_q;
        root_d        = root_q;
        dvd_d         = dvd_q;
        drem_d        = drem_q;
        quo_d         = quo_q;
        mem_d         = mem_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ch_d    = in_ch;
                    a0_d    = a0;
                    a1_d    = a1;
                    state_d = S_DISC;
                end
            end
            S_DISC: begin
                if (disc[2*W+1])       regime_d = 3'b001;
                else if (disc == '0)   regime_d = 3'b010;
                else                   regime_d = 3'b100;
                sigma_d = neg_a1[W:1];
                rad_d   = disc_abs[2*W-1:0];
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                state_d = S_SQRT;
            end
            S_SQRT: begin
                // W root iterations, then one cycle to derive kappa and pick the next step.
                if (cnt_q == CNTW'(W)) begin
                    kappa_d = {1'b0, root_q[W-1:1]};
                    if (root_q[W-1:1] == '0) begin
                        inv_kappa_d   = MAXPOS;
                        inv_invalid_d = 1'b1;
                        regime_chg_d  = chg_next;
                        state_d       = S_OUT;
                    end else begin
                        dvd_d   = {1'b1, {(QW-1){1'b0}}};
                        drem_d  = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = S_DIV;
                    end
                end else begin
                    rad_d  = rad_q << 2;
                    rem_d  = rem_n;
                    root_d = {root_q[W-2:0], ~rem_n[RW-1]};
                    cnt_d  = cnt_q + CNTW'(1);
                end
            end
            S_DIV: begin
                drem_d = div_ge ? W'(drem_sh - {1'b0, kappa_q}) : W'(drem_sh);
                dvd_d  = dvd_q << 1;
                quo_d  = quo_n;
                cnt_d  = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(QW - 1)) begin
                    inv_kappa_d   = div_sat ? MAXPOS : W'(quo_n);
                    inv_invalid_d = div_sat;
                    regime_chg_d  = chg_next;
                    state_d       = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (ch_ok) mem_d[ch_q] = regime_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_OUT);
        core_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            core_busy_q   <= 1'b0;
            ch_q          <= '0;
            a0_q          <= '0;
            a1_q          <= '0;
            regime_q      <= '0;
            regime_chg_q  <= 1'b0;
            sigma_q       <= '0;
            kappa_q       <= '0;
            inv_kappa_q   <= '0;
            inv_invalid_q <= 1'b0;
            cnt_q         <= '0;
            rad_q         <= '0;
            rem_q         <= '0;
            root_q        <= '0;
            dvd_q         <= '0;
            drem_q        <= '0;
            quo_q         <= '0;
            for (int i = 0; i < NCH; i++) mem_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            core_busy_q   <= core_busy_d;
            ch_q          <= ch_d;
            a0_q          <= a0_d;
            a1_q          <= a1_d;
            regime_q      <= regime_d;
            regime_chg_q  <= regime_chg_d;
            sigma_q       <= sigma_d;
            kappa_q       <= kappa_d;
            inv_kappa_q   <= inv_kappa_d;
            inv_invalid_q <= inv_invalid_d;
            cnt_q         <= cnt_d;
            rad_q         <= rad_d;
            rem_q         <= rem_d;
            root_q        <= root_d;
            dvd_q         <= dvd_d;
            drem_q        <= drem_d;
            quo_q         <= quo_d;
            mem_q         <= mem_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign core_busy   = core_busy_q;
    assign out_ch      = ch_q;
    assign regime      = regime_q;
    assign regime_chg  = regime_chg_q;
    assign sigma       = sigma_q;
    assign kappa       = kappa_q;
    assign inv_kappa   = inv_kappa_q;
    assign inv_invalid = inv_invalid_q;

endmodule

// File: tb/tb_eig_core_mc.sv
// Bench for eig_core_mc: constant vectors, hand-written corner sequences and randomized
// operations checked against an arithmetic reference model.
module tb_eig_core_mc;

    localparam int W = 32;
    localparam int F = 16;
    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int LAT_FULL = W + 2 * F + 3;
    localparam int LAT_ZERO = W + 2;
    localparam logic [W-1:0] MAXPOS = 32'h7FFF_FFFF;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [CHW-1:0] in_ch = '0;
    logic [W-1:0]   a0 = '0;
    logic [W-1:0]   a1 = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [CHW-1:0] out_ch;
    logic [2:0]     regime;
    logic           regime_chg;
    logic [W-1:0]   sigma, kappa, inv_kappa;
    logic           inv_invalid;
    logic           core_busy;
`ifdef EIG_CORE_MC_REGIME_CNT_EN
    logic           cnt_clr = 1'b0;
    logic [15:0]    cnt_over, cnt_crit, cnt_under;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [2:0] mem_model [NCH];

    typedef struct {
        logic [CHW-1:0] ch;
        logic [W-1:0]   a0;
        logic [W-1:0]   a1;
        logic [2:0]     regime;
        logic           chg;
        logic [W-1:0]   sigma;
        logic [W-1:0]   kappa;
        logic [W-1:0]   inv;
        logic           invalid;
        int             lat;
    } rec_t;

    eig_core_mc #(.W(W), .F(F), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .a0(a0), .a1(a1),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .regime(regime), .regime_chg(regime_chg), .sigma(sigma), .kappa(kappa),
        .inv_kappa(inv_kappa), .inv_invalid(inv_invalid),
`ifdef EIG_CORE_MC_REGIME_CNT_EN
        .cnt_clr(cnt_clr), .cnt_over(cnt_over), .cnt_crit(cnt_crit), .cnt_under(cnt_under),
`endif
        .core_busy(core_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic, bitwise search for the floor root, integer division.
    function automatic rec_t model_op(input logic [CHW-1:0] ch, input logic [W-1:0] a0_v,
                                      input logic [W-1:0] a1_v);
        rec_t r;
        longint a0s, a1s, d, s;
        longint unsigned mag, root, t, k, q;
        a0s = longint'($signed(a0_v));
        a1s = longint'($signed(a1_v));
        d = a1s * a1s - a0s * (longint'(1) <<< (F + 2));
        mag = (d < 0) ? longint'(-d) : d;
        root = 0;
        for (int b = W - 1; b >= 0; b--) begin
            t = root | (64'd1 << b);
            if (t * t <= mag) root = t;
        end
        k = root >> 1;
        s = (-a1s) >>> 1;
        r.ch = ch;
        r.a0 = a0_v;
        r.a1 = a1_v;
        r.regime = (d > 0) ? 3'b100 : ((d == 0) ? 3'b010 : 3'b001);
        r.chg = (mem_model[ch] != r.regime);
        r.sigma = s[W-1:0];
        r.kappa = k[W-1:0];
        if (k == 0) begin
            r.inv = MAXPOS;
            r.invalid = 1'b1;
            r.lat = LAT_ZERO;
        end else begin
            q = (64'd1 << (2 * F)) / k;
            r.inv = (q > 64'h7FFF_FFFF) ? MAXPOS : q[W-1:0];
            r.invalid = (q > 64'h7FFF_FFFF);
            r.lat = LAT_FULL;
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic [CHW-1:0] ch, input logic [W-1:0] a0_v,
                                 input logic [W-1:0] a1_v, output rec_t got, output bit ok);
        int n;
        ok = 1'b0;
        got = '{default: '0};
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_wait", {63'd0, in_ready}, 64'd1);
            return;
        end
        in_valid = 1'b1;
        in_ch = ch;
        a0 = a0_v;
        a1 = a1_v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (!out_valid) begin
            checkOutput("out_valid_timeout", {63'd0, out_valid}, 64'd1);
            return;
        end
        got.ch = out_ch;
        got.regime = regime;
        got.chg = regime_chg;
        got.sigma = sigma;
        got.kappa = kappa;
        got.inv = inv_kappa;
        got.invalid = inv_invalid;
        got.lat = n;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic run_and_check(input string tag, input rec_t exp);
        rec_t got;
        bit ok;
        applyStimulus(exp.ch, exp.a0, exp.a1, got, ok);
        if (ok) begin
            checkOutput({tag, ".regime"}, 64'(got.regime), 64'(exp.regime));
            checkOutput({tag, ".chg"}, 64'(got.chg), 64'(exp.chg));
            checkOutput({tag, ".sigma"}, 64'(got.sigma), 64'(exp.sigma));
            checkOutput({tag, ".kappa"}, 64'(got.kappa), 64'(exp.kappa));
            checkOutput({tag, ".inv_kappa"}, 64'(got.inv), 64'(exp.inv));
            checkOutput({tag, ".inv_invalid"}, 64'(got.invalid), 64'(exp.invalid));
            checkOutput({tag, ".latency"}, 64'(got.lat), 64'(exp.lat));
            checkOutput({tag, ".out_ch"}, 64'(got.ch), 64'(exp.ch));
            checkOutput({tag, ".out_valid_drop"}, {63'd0, out_valid}, 64'd0);
            mem_model[exp.ch] = exp.regime;
        end
    endtask

    initial begin
        rec_t vecs[3];
        rec_t e;
        logic [W-1:0] cap_sigma, cap_kappa, cap_inv;
        int n;

        // ch, a0, a1, regime, chg (filled at run time), sigma, kappa, inv, invalid, latency
        vecs[0] = '{2'd0, 32'h0001_0000, 32'h0003_0000, 3'b100, 1'b0, 32'hFFFE_8000,
                    32'h0001_1E37, 32'h0000_E4F9, 1'b0, LAT_FULL};
        vecs[1] = '{2'd1, 32'h0001_0000, 32'h0002_0000, 3'b010, 1'b0, 32'hFFFF_0000,
                    32'h0000_0000, 32'h7FFF_FFFF, 1'b1, LAT_ZERO};
        vecs[2] = '{2'd0, 32'h0002_0000, 32'h0002_0000, 3'b001, 1'b0, 32'hFFFF_0000,
                    32'h0001_0000, 32'h0001_0000, 1'b0, LAT_FULL};

        for (int i = 0; i < NCH; i++) mem_model[i] = 3'b000;
        repeat (3) @(negedge clk);
        checkOutput("rst.in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("rst.out_valid", {63'd0, out_valid}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst.core_busy", {63'd0, core_busy}, 64'd0);
        checkOutput("rst.data", {sigma, kappa}, 64'd0);
        checkOutput("rst.inv", {inv_kappa, 24'd0, 3'd0, regime, regime_chg, inv_invalid}, 64'd0);

        for (int i = 0; i < 3; i++) begin
            e = vecs[i];
            e.chg = (mem_model[e.ch] != e.regime);
            run_and_check($sformatf("vec%0d", i), e);
        end

        // Backpressure: result must hold while in_valid toggles and out_ready stays low.
        in_valid = 1'b1;
        in_ch = 2'd1;
        a0 = 32'h0001_0000;
        a1 = 32'h0003_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checkOutput("bp.out_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("bp.sigma", 64'(sigma), 64'h0000_0000_FFFE_8000);
        checkOutput("bp.kappa", 64'(kappa), 64'h0000_0000_0001_1E37);
        cap_sigma = sigma;
        cap_kappa = kappa;
        cap_inv = inv_kappa;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_ch = CHW'($urandom_range(0, NCH - 1));
            a0 = $urandom;
            a1 = $urandom;
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("bp.in_ready%0d", i), {63'd0, in_ready}, 64'd0);
            checkOutput($sformatf("bp.hold_valid%0d", i), {63'd0, out_valid}, 64'd1);
            checkOutput($sformatf("bp.hold_data%0d", i), {sigma, kappa ^ inv_kappa},
                        {cap_sigma, cap_kappa ^ cap_inv});
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp.after_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("bp.after_busy", {63'd0, core_busy}, 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        mem_model[1] = 3'b100;

        // Reset in the middle of the root iterations aborts silently.
        in_valid = 1'b1;
        in_ch = 2'd0;
        a0 = 32'h0001_0000;
        a1 = 32'h0003_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("mid.busy", {63'd0, core_busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid.out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("mid.in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("mid.data", {sigma, kappa}, 64'd0);
        checkOutput("mid.regime", {inv_kappa, 27'd0, regime, inv_invalid, regime_chg}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) mem_model[i] = 3'b000;
        @(negedge clk);
        checkOutput("mid.release_ready", {63'd0, in_ready}, 64'd1);

        // Regime-change history: ch2 under, ch2 under, ch3 under, ch2 over -> 1,0,1,1.
        e = vecs[2]; e.ch = 2'd2; e.chg = 1'b1; run_and_check("chg0", e);
        e = vecs[2]; e.ch = 2'd2; e.chg = 1'b0; run_and_check("chg1", e);
        e = vecs[2]; e.ch = 2'd3; e.chg = 1'b1; run_and_check("chg2", e);
        e = vecs[0]; e.ch = 2'd2; e.chg = 1'b1; run_and_check("chg3", e);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra0, ra1;
            int mode, m;
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin ra0 = $urandom; ra1 = $urandom; end
                1: begin
                    ra0 = W'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
                    ra1 = W'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
                end
                2: begin
                    m = $urandom_range(0, 180);
                    ra0 = W'(m * m);
                    ra1 = W'(m * 512);
                    if ($urandom_range(0, 1) == 1) ra1 = -ra1;
                end
                default: begin ra0 = $urandom; ra1 = 32'h8000_0000; end
            endcase
            e = model_op(CHW'($urandom_range(0, NCH - 1)), ra0, ra1);
            run_and_check($sformatf("rnd%0d", i), e);
        end

`ifdef EIG_CORE_MC_REGIME_CNT_EN
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) run_and_check($sformatf("cnt_over%0d", i), model_op(2'd0, vecs[0].a0, vecs[0].a1));
        run_and_check("cnt_crit", model_op(2'd1, vecs[1].a0, vecs[1].a1));
        checkOutput("cnt.over", 64'(cnt_over), 64'd3);
        checkOutput("cnt.crit", 64'(cnt_crit), 64'd1);
        checkOutput("cnt.under", 64'(cnt_under), 64'd0);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checkOutput("cnt.clr", {16'd0, cnt_over, cnt_crit, cnt_under}, 64'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
